tristate_bus_arbiter: RTL and testbench
=======================================

# tristate_bus_arbiter

Round-robin arbiter and driver controller for a shared tristate data bus. Up to N requesters compete for the bus. The block grants one at a time and enables exactly one tristate driver onto the shared `bus` net. It inserts turnaround cycles so two drivers are never enabled together. It sits directly upstream of the tristate multiplexer stage: its one-hot `oe` vector is the select/enable set that stage consumes. A downstream consumer accepts each word with a valid/ready handshake.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: data width of each requester and of `bus`.
- `TIMEOUT`, default 15: maximum number of DRIVE cycles spent waiting for `bus_ready` before a forced release, 1..255.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, N: `req[i]` high means requester i wants one bus transfer.
- `din`, input, N*WIDTH: requester data; `din[i*WIDTH +: WIDTH]` belongs to requester i.
- `gnt`, output, N: registered one-hot grant; all zero when the bus is free.
- `oe`, output, N: registered one-hot tristate enables; `oe[i]` drives `din[i]` onto `bus`.
- `bus`, inout, WIDTH: shared net; equals the selected `din` when any `oe` bit is high, otherwise all bits `z`.
- `bus_valid`, output, 1: a word is on `bus`.
- `bus_ready`, input, 1: the consumer accepts the word in this cycle.
- `done`, output, N: one-cycle pulse on `done[i]` when requester i's word is accepted.
- `err`, output, 1: one-cycle pulse on a timeout release.

## Operation
- States: IDLE, GRANT, DRIVE, RELEASE. All outputs are registered.
- Reset values: state IDLE, `gnt`=0, `oe`=0, `bus`=z, `bus_valid`=0, `done`=0, `err`=0.
- Reset sets the round-robin pointer so that requester 0 has highest priority. Reset also clears the timeout counter.
- IDLE:
  - If `req`≠0, select the first requesting index at or after the pointer, with wrap-around.
  - Set `gnt` one-hot for that index and go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT (one turnaround cycle):
  - `gnt` is held and `oe`=0, so `bus` is z.
  - If `req` of the granted index is still high, set `oe` for that index, set `bus_valid`=1, clear the counter, and go to DRIVE.
  - If that `req` has dropped, clear `gnt` and go to IDLE. No transfer occurs and the pointer does not change.
- DRIVE:
  - `oe` and `bus_valid` are held; `bus` follows live `din` of the granted index.
  - When `bus_ready` is high, pulse `done[granted]`, then clear `oe`, `gnt` and `bus_valid`. Set the pointer to granted+1 (mod N) and go to RELEASE.
  - When `bus_ready` is low, increment the counter. If the counter reaches TIMEOUT, perform the same release with `err` pulsed and no `done` pulse. The pointer still advances.
  - Deassertion of `req` while in DRIVE is ignored.
- RELEASE (one turnaround cycle): all `oe`=0 and `bus`=z; go to IDLE.
- Every transfer costs at least 4 cycles: IDLE, GRANT, DRIVE, RELEASE.
- Invariants:
  - `$countones(oe)` ≤ 1 at all times.
  - `oe` is never nonzero in the cycle directly after a different `oe` bit was high.
  - `oe` ≠ 0 implies `gnt` = `oe`.
- Simultaneous requests are resolved by pointer order only. A requester that holds `req` is served within N transfers.

## Timing
- From `req` rising in IDLE at edge k:
  - `gnt` is visible after edge k.
  - `oe` and `bus_valid` are visible after edge k+1.
- With `bus_ready` high in the first DRIVE cycle, `done` pulses for exactly one cycle after edge k+2. At the same edge, `oe` and `gnt` return to 0.
- The earliest next `gnt` appears after edge k+4.
- `bus_ready` is sampled only in DRIVE and ignored in every other state.
- `rst` high at any edge forces the reset values at that edge, including mid-DRIVE. `bus` is z in the following cycle, and no `done` or `err` is generated for the aborted transfer.

## Test plan
- Single requester: N=4, `req`=4'b0100, `din[2]`=8'hA5, `bus_ready` held high.
  - Required: `gnt`=0100 for 2 cycles.
  - Required: `oe`=0100 for 1 cycle with `bus`=A5.
  - Required: `done`=0100 pulses once; `bus` is z in all other cycles.
- All request simultaneously: `req`=1111 held, `bus_ready`=1.
  - Required grant order 0,1,2,3,0.
  - Required: each transfer 4 cycles apart; `oe` never two-hot.
- Backpressure: `bus_ready` low for 3 DRIVE cycles, then high.
  - Required: `bus_valid` and `bus` stable for 4 cycles.
  - Required: `done` pulses on the 4th cycle; `err`=0.
- Timeout: TIMEOUT=15, `bus_ready` held low.
  - Required: `err` pulses after 15 DRIVE cycles, `done` stays 0, `oe` returns to 0.
  - Required: the next grant goes to the next index.
- Grant withdrawal: requester 1 drops `req` during GRANT.
  - Required: no `oe`, back to IDLE, the pointer stays at 1.
- Reset mid-DRIVE: assert `rst` for one cycle.
  - Required: all outputs reach reset values after that edge, `bus`=z, and no `done` pulse.
  - Required: the next arbitration starts from requester 0.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin arbiter driving one tristate enable at a time onto a shared bus
// Ports: clk/rst (sync, active-high); req[N] requests; din[N*WIDTH] requester words;
// gnt[N] registered one-hot grant; oe[N] registered one-hot driver enables; bus shared net;
// bus_valid word present; bus_ready consumer accept; done[N] accept pulse; err timeout pulse.
module tristate_bus_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       oe,
  inout  wire  [WIDTH-1:0]   bus,
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic [N-1:0]       done,
  output logic               err
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, DRIVE, RELEASE} state_t;
  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d, idx_q, idx_d, sel;
  logic [N-1:0]   gnt_q, gnt_d, oe_q, oe_d, done_q, done_d;
  logic           valid_q, valid_d, err_q, err_d, found;
  logic [7:0]     cnt_q, cnt_d;
  logic           release_now;
  // Scan downward so the lowest offset from the pointer is the last (winning) hit.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % N]) begin
        sel   = IW'((int'(ptr_q) + k) % N);
        found = 1'b1;
      end
    end
  end
  assign release_now = bus_ready || (cnt_q + 8'd1 == 8'(TIMEOUT));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    oe_d    = oe_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel;
        idx_d   = sel;
        state_d = GRANT;
      end
      GRANT: if (req[idx_q]) begin
        oe_d    = gnt_q;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = DRIVE;
      end else begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      DRIVE: if (release_now) begin
        done_d  = bus_ready ? gnt_q : '0;
        err_d   = !bus_ready;
        oe_d    = '0;
        gnt_d   = '0;
        valid_d = 1'b0;
        ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
        state_d = RELEASE;
      end else begin
        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      oe_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign gnt       = gnt_q;
  assign oe        = oe_q;
  assign bus_valid = valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bus       = |oe_q ? din[idx_q*WIDTH +: WIDTH] : {WIDTH{1'bz}};
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: directed vector bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;
  logic        clk = 1'b0, rst = 1'b1, bus_ready = 1'b0, bus_valid, err;
  logic [3:0]  req = '0, gnt, oe, done;
  logic [31:0] din = {8'hD3, 8'hA5, 8'h5C, 8'h3E};
  wire  [7:0]  bus;
  wire         bus_z = (bus === 8'bzzzzzzzz);
  int          n_cmp = 0, n_bad = 0;
  logic        mon_en = 1'b0;
  logic [3:0]  prev_oe = '0;
  typedef struct {
    logic       r;
    logic [3:0] q;
    logic       rdy;
    logic [3:0] g, o;
    logic       v;
    logic [3:0] d;
    logic       e;
  } vec_t;
  vec_t tbl[$];
  tristate_bus_arbiter #(.N(4), .WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .oe(oe), .bus(bus),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] bus_of(logic [3:0] o);
    return o[0] ? 8'h3E : o[1] ? 8'h5C : o[2] ? 8'hA5 : 8'hD3;
  endfunction
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic step(logic r, logic [3:0] q, logic rdy);
    rst = r;
    req = q;
    bus_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(string tag, logic [3:0] g, logic [3:0] o, logic v, logic [3:0] d, logic e);
    chk({tag, ".gnt"}, 8'(gnt), 8'(g));
    chk({tag, ".oe"}, 8'(oe), 8'(o));
    chk({tag, ".bus_valid"}, 8'(bus_valid), 8'(v));
    chk({tag, ".done"}, 8'(done), 8'(d));
    chk({tag, ".err"}, 8'(err), 8'(e));
    if (o == 4'b0) chk({tag, ".bus_z"}, 8'(bus_z), 8'd1);
    else chk({tag, ".bus"}, bus, bus_of(o));
  endtask
  function automatic void add(logic r, logic [3:0] q, logic rdy, logic [3:0] g, logic [3:0] o,
                              logic v, logic [3:0] d, logic e);
    tbl.push_back('{r, q, rdy, g, o, v, d, e});
  endfunction
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_onehot", 8'($countones(oe) <= 1), 8'd1);
      chk("inv_gnt_eq_oe", 8'(oe != 4'b0 && gnt != oe), 8'd0);
      chk("inv_turnaround", 8'(prev_oe != 4'b0 && oe != 4'b0 && oe != prev_oe), 8'd0);
      prev_oe = oe;
    end
  end
  initial begin
    logic [3:0] m;
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0100, 1, 4'b0100, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0100, 1, 4'b0100, 4'b0100, 1, 4'b0000, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0100, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      m = 4'b0001 << (i % 4);
      add(0, 4'b1111, 1, m, 4'b0000, 0, 4'b0000, 0);
      add(0, 4'b1111, 1, m, m, 1, 4'b0000, 0);
      add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0, m, 0);
      add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    end
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q, tbl[i].rdy);
      mon_en = 1'b1;
      expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].o, tbl[i].v, tbl[i].d, tbl[i].e);
    end
    step(0, 4'b0010, 0); expect_out("bp_gnt", 4'b0010, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0010, 0); expect_out("bp_drive0", 4'b0010, 4'b0010, 1, 4'b0000, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 4'b0010, 0);
      expect_out($sformatf("bp_wait%0d", i), 4'b0010, 4'b0010, 1, 4'b0000, 0);
    end
    step(0, 4'b0000, 1); expect_out("bp_done", 4'b0000, 4'b0000, 0, 4'b0010, 0);
    step(0, 4'b0000, 0); expect_out("bp_rel", 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0100, 0); expect_out("to_gnt", 4'b0100, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0100, 0); expect_out("to_drive0", 4'b0100, 4'b0100, 1, 4'b0000, 0);
    for (int i = 1; i <= 14; i++) begin
      step(0, 4'b0000, 0);
      expect_out($sformatf("to_wait%0d", i), 4'b0100, 4'b0100, 1, 4'b0000, 0);
    end
    step(0, 4'b0000, 0); expect_out("to_err", 4'b0000, 4'b0000, 0, 4'b0000, 1);
    step(0, 4'b1111, 0); expect_out("to_rel", 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b1111, 0); expect_out("to_next", 4'b1000, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b1111, 1); expect_out("to_next_drv", 4'b1000, 4'b1000, 1, 4'b0000, 0);
    step(0, 4'b0000, 1); expect_out("to_next_done", 4'b0000, 4'b0000, 0, 4'b1000, 0);
    step(0, 4'b0000, 0); expect_out("to_next_rel", 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0001, 1); expect_out("wd_pre_gnt", 4'b0001, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0001, 1); expect_out("wd_pre_drv", 4'b0001, 4'b0001, 1, 4'b0000, 0);
    step(0, 4'b0000, 1); expect_out("wd_pre_done", 4'b0000, 4'b0000, 0, 4'b0001, 0);
    step(0, 4'b0000, 0); expect_out("wd_pre_rel", 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0010, 0); expect_out("wd_gnt", 4'b0010, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b0000, 0); expect_out("wd_drop", 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b1111, 0); expect_out("wd_ptr_kept", 4'b0010, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b1111, 0); expect_out("rst_pre_drv", 4'b0010, 4'b0010, 1, 4'b0000, 0);
    step(1, 4'b1111, 1); expect_out("rst_mid", 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b1111, 1); expect_out("rst_regnt", 4'b0001, 4'b0000, 0, 4'b0000, 0);
    step(0, 4'b1111, 1); expect_out("rst_drv", 4'b0001, 4'b0001, 1, 4'b0000, 0);
    step(0, 4'b0000, 1); expect_out("rst_done", 4'b0000, 4'b0000, 0, 4'b0001, 0);
    step(0, 4'b0000, 0); expect_out("rst_rel", 4'b0000, 4'b0000, 0, 4'b0000, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
